// File: rtl/vga_sync_if.sv
// Video timing bundle: counters, syncs and per-pixel strobes from vga_sync.
// The master drives every signal; consumers attach through the slave modport.
interface vga_sync_if;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;

    modport master (
        output pix_en, hsync, vsync, video_on,
        output pixel_x, pixel_y, line_start, frame_start
    );

    modport slave (
        input pix_en, hsync, vsync, video_on,
        input pixel_x, pixel_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync.sv
// VGA timing generator: a 1/4 prescaler drives the pixel counters, and every
// output is registered from the next-state counters so all outputs stay aligned.
module vga_sync #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic         clk_100mhz,
    input  logic         rst,
    vga_sync_if.master   vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [1:0] div_cnt_q, div_cnt_d;
    logic       tick;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       pix_en_q, pix_en_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        div_cnt_d = div_cnt_q + 2'd1;
        tick      = (div_cnt_q == 2'd3);

        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end

        // Decoding the next-state counters keeps syncs in step with pixel_x/y;
        // between ticks the counters hold, so the decode holds too.
        hsync_d       = !((h_cnt_d >= HS_START) && (h_cnt_d < HS_END));
        vsync_d       = !((v_cnt_d >= VS_START) && (v_cnt_d < VS_END));
        video_on_d    = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
        pix_en_d      = tick;
        line_start_d  = tick && (h_cnt_d == 10'd0);
        frame_start_d = tick && (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
    end

    // Reset parks the counters on the last position of the frame, so the
    // first tick after release lands exactly on (0, 0).
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            div_cnt_q     <= 2'd0;
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            pix_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pix_en_q      <= pix_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pixel_x     = h_cnt_q;
    assign vga.pixel_y     = v_cnt_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pix_en      = pix_en_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default timing against a hand-built vector table, and a
// reduced timing against an arithmetic model under random resets.
module tb_vga_sync;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1;
    logic rst_s = 1'b1;

    vga_sync_if if_d();
    vga_sync_if if_s();

    vga_sync u_dut_d (
        .clk_100mhz (clk),
        .rst        (rst_d),
        .vga        (if_d)
    );

    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1;

    vga_sync #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB)
    ) u_dut_s (
        .clk_100mhz (clk),
        .rst        (rst_s),
        .vga        (if_s)
    );

    int checks = 0;
    int errors = 0;

    // Packed view: {x[10], y[10], hsync, vsync, video_on, pix_en, line_start, frame_start}
    function automatic logic [25:0] get_d();
        return {if_d.pixel_x, if_d.pixel_y, if_d.hsync, if_d.vsync, if_d.video_on,
                if_d.pix_en, if_d.line_start, if_d.frame_start};
    endfunction

    function automatic logic [25:0] get_s();
        return {if_s.pixel_x, if_s.pixel_y, if_s.hsync, if_s.vsync, if_s.video_on,
                if_s.pix_en, if_s.line_start, if_s.frame_start};
    endfunction

    // k = clock edges since the last edge that saw rst high (0 = that edge).
    // Ticks land on k = 4, 8, ...; tick t shows scan position t-1 of the frame.
    function automatic logic [25:0] model_out(int k, int ha, int hf, int hs, int hb,
                                               int va, int vf, int vs, int vb);
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int fr = ht * vt;
        int t  = k / 4;
        int p  = (t % fr + fr - 1) % fr;
        int x  = p % ht;
        int y  = p / ht;
        logic pe   = (k > 0) && (k % 4 == 0);
        logic hs_n = !((x >= ha + hf) && (x < ha + hf + hs));
        logic vs_n = !((y >= va + vf) && (y < va + vf + vs));
        logic vo   = (x < ha) && (y < va);
        return {10'(x), 10'(y), hs_n, vs_n, vo, pe, pe && (x == 0), pe && (x == 0) && (y == 0)};
    endfunction

    task automatic check_vec(string name, int k, logic [25:0] act, logic [25:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got x=%0d y=%0d hs/vs/vo/pe/ls/fs=%b want x=%0d y=%0d hs/vs/vo/pe/ls/fs=%b",
                     name, k, act[25:16], act[15:6], act[5:0], exp[25:16], exp[15:6], exp[5:0]);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         k;
        int         x;
        int         y;
        logic [5:0] f;   // hsync, vsync, video_on, pix_en, line_start, frame_start
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [25:0] act;
        int idx, ks, rst_left;
        int hs_low_cnt, hs_first_x, vo_cnt, ls_cnt, ls_first, ls_last, pe_prev, pe_bad;

        tbl[0]  = '{k: 0,    x: 799, y: 524, f: 6'b110000};
        tbl[1]  = '{k: 3,    x: 799, y: 524, f: 6'b110000};
        tbl[2]  = '{k: 4,    x: 0,   y: 0,   f: 6'b111111};
        tbl[3]  = '{k: 5,    x: 0,   y: 0,   f: 6'b111000};
        tbl[4]  = '{k: 8,    x: 1,   y: 0,   f: 6'b111100};
        tbl[5]  = '{k: 2560, x: 639, y: 0,   f: 6'b111100};
        tbl[6]  = '{k: 2564, x: 640, y: 0,   f: 6'b110100};
        tbl[7]  = '{k: 2628, x: 656, y: 0,   f: 6'b010100};
        tbl[8]  = '{k: 3008, x: 751, y: 0,   f: 6'b010100};
        tbl[9]  = '{k: 3012, x: 752, y: 0,   f: 6'b110100};
        tbl[10] = '{k: 3200, x: 799, y: 0,   f: 6'b110100};
        tbl[11] = '{k: 3204, x: 0,   y: 1,   f: 6'b111110};
        tbl[12] = '{k: 3206, x: 0,   y: 1,   f: 6'b111000};

        // Default timing: reset release, first tick, one full line and its wrap.
        repeat (2) @(negedge clk);
        rst_d = 1'b0;
        idx = 0;
        hs_low_cnt = 0; hs_first_x = -1; vo_cnt = 0;
        ls_cnt = 0; ls_first = -1; ls_last = -1; pe_prev = -1; pe_bad = 0;
        for (int k = 0; k <= 3206; k++) begin
            if (k > 0) @(negedge clk);
            act = get_d();
            while (idx < 13 && tbl[idx].k == k) begin
                check_vec("default_vec", k, act,
                          {10'(tbl[idx].x), 10'(tbl[idx].y), tbl[idx].f});
                idx++;
            end
            if (act[2]) begin
                if (pe_prev >= 0 && k - pe_prev != 4) pe_bad++;
                pe_prev = k;
                if (act[15:6] == 10'd0) begin
                    if (!act[5]) begin
                        hs_low_cnt++;
                        if (hs_first_x < 0) hs_first_x = int'(act[25:16]);
                    end
                    if (act[3]) vo_cnt++;
                end
            end
            if (act[1]) begin
                ls_cnt++;
                if (ls_first < 0) ls_first = k;
                ls_last = k;
            end
        end
        check_int("table_rows_seen", idx, 13);
        check_int("pix_en_period_errs", pe_bad, 0);
        check_int("hsync_low_pix_per_line", hs_low_cnt, 96);
        check_int("hsync_first_low_x", hs_first_x, 656);
        check_int("video_on_pix_line0", vo_cnt, 640);
        check_int("line_start_count", ls_cnt, 2);
        check_int("line_start_interval", ls_last - ls_first, 3200);
        rst_d = 1'b1;

        // Reduced timing, random resets, every cycle against the model.
        ks = 0;
        rst_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (rst_left > 0) begin
                rst_s = 1'b1;
                rst_left--;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_s = 1'b1;
                rst_left = $urandom_range(0, 2);
            end else begin
                rst_s = 1'b0;
            end
            @(negedge clk);
            ks = rst_s ? 0 : ks + 1;
            check_vec("random_model", ks, get_s(),
                      model_out(ks, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB));
        end

        // Mid-frame reset coincident with the tick leaving (5, 2).
        rst_s = 1'b1;
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        for (int k = 1; k <= 147; k++) begin
            @(negedge clk);
            if (k == 147)
                check_vec("pre_reset_pos", k, get_s(),
                          {10'd5, 10'd2, 6'b111000});
        end
        rst_s = 1'b1;
        @(negedge clk);
        check_vec("midframe_reset_vals", 148, get_s(), {10'd14, 10'd7, 6'b110000});
        rst_s = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4)
                check_vec("post_reset_hold", k, get_s(), {10'd14, 10'd7, 6'b110000});
            else
                check_vec("post_reset_frame_start", k, get_s(), {10'd0, 10'd0, 6'b111111});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_ACTIVE 640: visible pixels per line.
- H_FP 16: horizontal front porch, in pixels.
- H_SYNC 96: hsync pulse width, in pixels.
- H_BP 48: horizontal back porch, in pixels.
- V_ACTIVE 480: visible lines per frame.
- V_FP 10: vertical front porch, in lines.
- V_SYNC 2: vsync pulse width, in lines.
- V_BP 33: vertical back porch, in lines.
REQ-002 Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk_100mhz  in  1  the single system clock.
- rst  in  1  synchronous active-high reset.
- pix_en  out  1  one-cycle pulse marking that the pixel outputs have just updated.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- video_on  out  1  high while the current pixel is in the visible area.
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1.
- line_start  out  1  pulse when pixel_x becomes 0.
- frame_start  out  1  pulse when (pixel_x, pixel_y) becomes (0, 0).
REQ-004 The block has one clock, clk_100mhz; rst is synchronous and active-high; no other clock or derived clock is used.

Function
REQ-005 A 2-bit prescaler div_cnt shall increment on every clk_100mhz edge and wrap from 3 to 0.
REQ-006 The internal tick is (div_cnt == 3); pixel state advances only on edges where tick is true, i.e. once every 4 clocks (25 MHz rate).
REQ-007 On a tick edge, h_cnt shall increment; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
REQ-008 v_cnt shall wrap from V_TOTAL-1 to 0 on the same edge that h_cnt wraps.
REQ-009 All outputs shall be registered and updated on the tick edge from the next-state counter values, so they are mutually consistent with zero skew.
REQ-010 pixel_x and pixel_y shall equal h_cnt and v_cnt respectively.
REQ-011 hsync shall be 0 iff H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
REQ-012 vsync shall be 0 iff V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
REQ-013 video_on shall be 1 iff pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
REQ-014 pix_en shall be high for exactly the one clock cycle following each tick edge and low otherwise.
REQ-015 line_start and frame_start shall be high only in pix_en cycles, when the new pixel_x is 0 (line_start) or the new position is (0, 0) (frame_start).
REQ-016 frame_start implies line_start in the same cycle.
REQ-017 Between ticks, all outputs except pix_en, line_start and frame_start shall hold their values.

Reset
REQ-018 While rst is 1 at a clock edge, the following values shall be loaded:
- div_cnt = 0;
- h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, so pixel_x = 799 and pixel_y = 524;
- hsync = 1, vsync = 1, video_on = 0;
- pix_en = 0, line_start = 0, frame_start = 0.
REQ-019 The reset values are the legal decode of position (799, 524), so no output glitch occurs at reset release.
REQ-020 The first tick after rst deasserts shall occur on the 4th clock edge and move the position to (0, 0), with video_on = 1 and frame_start = line_start = pix_en = 1.
REQ-021 rst asserted mid-frame shall take priority over any tick on the same edge and abandon the frame immediately.
REQ-022 After a mid-frame reset, timing restarts per REQ-020 with no partial-line carry-over.

Verification
REQ-023 Reset release: outputs hold the REQ-018 values for 3 clocks. On the 4th edge: pixel (0,0), video_on=1, frame_start=1, pix_en=1 for one cycle.
REQ-024 Cadence: pix_en rises every 4 clocks exactly. line_start rises every 3200 clocks. frame_start rises every 1,680,000 clocks.
REQ-025 Horizontal: per line, hsync=0 for exactly 96 consecutive pix_en cycles, beginning at pixel_x=656. video_on drops after pixel_x=639.
REQ-026 Vertical: vsync=0 exactly during lines 490-491 (1600 pix_en cycles). There are 307,200 video_on pix_en cycles per frame.
REQ-027 Wrap: at (799,524), the next tick gives (0,0) and frame_start. At (799,k) for k<524, the next tick gives (0,k+1) and line_start only.
REQ-028 Mid-frame reset: assert rst for 1 cycle at (300,200) coincident with a tick. The next cycle shows the REQ-018 values, and frame_start recurs 4 clocks after release.
